// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and a state decode helper.
// The CHK state exists only when PROG_LOADER_CHKSUM_EN is defined.
package prog_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_INSTR = 3'd2,
    ST_ARG   = 3'd3,
`ifdef PROG_LOADER_CHKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd5
  } state_t;

  // True for the states that consume a byte from the stream.
  function automatic logic accepts_byte(input state_t s);
    logic r;
    case (s)
      ST_LEN, ST_INSTR, ST_ARG: r = 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
      ST_CHK:                   r = 1'b1;
`endif
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream and program-memory write bus of the loader.
// slave = the loader itself; master = the byte source and the program ROM write port.
interface prog_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_instr;
  logic [WIDTH-1:0] wr_arg;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_instr, wr_arg
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_instr, wr_arg
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives length + instr/arg pairs and writes them into program memory.
// Optional XOR checksum byte at the end of the stream, enabled by PROG_LOADER_CHKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

`ifdef PROG_LOADER_CHKSUM_EN
  localparam state_t ST_FINAL = ST_CHK;
`else
  localparam state_t ST_FINAL = ST_DONE;
`endif

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] addr_r;
  logic [WIDTH-1:0] instr_r;
  logic [WIDTH-1:0] wr_addr_r;
  logic [WIDTH-1:0] wr_instr_r;
  logic [WIDTH-1:0] wr_arg_r;
  logic             wr_en_r;
  logic             done_r;
  logic             hold_r;
  logic             ready_r;
  logic [WIDTH-1:0] addr_inc_s;
  logic             xfer_s;
  logic             last_s;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [WIDTH-1:0] chk_r;
  logic             err_r;
  logic             chk_ok_s;

  assign chk_ok_s = (bus.byte_in == chk_r);
  assign err      = err_r;
`else
  assign err      = 1'b0;
`endif

  // N never exceeds 2**WIDTH-1, so addr_r+1 fits and the counter never wraps.
  assign xfer_s     = bus.byte_valid & ready_r;
  assign addr_inc_s = addr_r + WIDTH'(1);
  assign last_s     = (addr_inc_s == n_r);

  assign bus.byte_ready = ready_r;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_instr   = wr_instr_r;
  assign bus.wr_arg     = wr_arg_r;
  assign cpu_hold       = hold_r;
  assign done           = done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx = ST_LEN;
        else       state_nx = ST_IDLE;
      end
      ST_LEN: begin
        if (xfer_s) begin
          if (bus.byte_in == {WIDTH{1'b0}}) state_nx = ST_FINAL;
          else                              state_nx = ST_INSTR;
        end else begin
          state_nx = ST_LEN;
        end
      end
      ST_INSTR: begin
        if (xfer_s) state_nx = ST_ARG;
        else        state_nx = ST_INSTR;
      end
      ST_ARG: begin
        if (xfer_s) begin
          if (last_s) state_nx = ST_FINAL;
          else        state_nx = ST_INSTR;
        end else begin
          state_nx = ST_ARG;
        end
      end
`ifdef PROG_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          if (chk_ok_s) state_nx = ST_DONE;
          else          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_CHK;
        end
      end
`endif
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r        <= {WIDTH{1'b0}};
      addr_r     <= {WIDTH{1'b0}};
      instr_r    <= {WIDTH{1'b0}};
      wr_addr_r  <= {WIDTH{1'b0}};
      wr_instr_r <= {WIDTH{1'b0}};
      wr_arg_r   <= {WIDTH{1'b0}};
      wr_en_r    <= 1'b0;
      done_r     <= 1'b0;
      hold_r     <= 1'b0;
      ready_r    <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_r      <= {WIDTH{1'b0}};
      err_r      <= 1'b0;
`endif
    end else begin
      ready_r <= accepts_byte(state_nx);
      done_r  <= (state_nx == ST_DONE);
      wr_en_r <= 1'b0;
      // cpu_hold drops only for the DONE cycle; a checksum failure leaves it set.
      if (state_nx == ST_DONE) hold_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            hold_r <= 1'b1;
            addr_r <= {WIDTH{1'b0}};
`ifdef PROG_LOADER_CHKSUM_EN
            chk_r  <= {WIDTH{1'b0}};
            err_r  <= 1'b0;
`endif
          end
        end
        ST_LEN: begin
          if (xfer_s) n_r <= bus.byte_in;
        end
        ST_INSTR: begin
          if (xfer_s) begin
            instr_r <= bus.byte_in;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_r   <= chk_r ^ bus.byte_in;
`endif
          end
        end
        ST_ARG: begin
          if (xfer_s) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= addr_r;
            wr_instr_r <= instr_r;
            wr_arg_r   <= bus.byte_in;
            addr_r     <= addr_inc_s;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_r      <= chk_r ^ bus.byte_in;
`endif
          end
        end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_CHK: begin
          if (xfer_s && !chk_ok_s) err_r <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: WIDTH, default 8, sets the data width, the program address width and the maximum program length.
REQ-002 Port: clk  in  1  system clock; all logic is on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: start  in  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-005 Port: byte_in  in  WIDTH  incoming byte stream: length byte, then instr/arg byte pairs, then an optional checksum byte.
REQ-006 Port: byte_valid  in  1  byte_in holds a valid byte.
REQ-007 Port: byte_ready  out  1  the loader can accept a byte; a transfer occurs when byte_valid and byte_ready are both 1 on the same edge.
REQ-008 Port: wr_en  out  1  one-cycle write strobe into program memory.
REQ-009 Port: wr_addr  out  WIDTH  program memory address to write.
REQ-010 Port: wr_instr  out  WIDTH  instruction byte to write.
REQ-011 Port: wr_arg  out  WIDTH  argument byte to write.
REQ-012 Port: cpu_hold  out  1  holds the program counter in reset while a load is in progress.
REQ-013 Port: done  out  1  one-cycle pulse when a load completes successfully.
REQ-014 Port: err  out  1  sticky checksum-failure flag.

Function
REQ-015 The FSM SHALL have the states IDLE, LEN, INSTR, ARG, CHK and DONE.
REQ-016 byte_ready SHALL be 1 in LEN, INSTR, ARG and CHK, and 0 in IDLE and DONE.
REQ-017 In IDLE, start SHALL cause the following on the next edge:
- state goes to LEN;
- cpu_hold goes to 1;
- err clears;
- the address counter and the checksum both clear to 0.
REQ-018 In LEN, a transfer SHALL latch N = byte_in.
- N = 0: go to CHK when PROG_LOADER_CHKSUM_EN is defined, otherwise go to DONE.
- N > 0: go to INSTR.
REQ-019 In INSTR, a transfer SHALL latch the instruction byte and move to ARG.
REQ-020 In ARG, a transfer SHALL cause, on the next cycle only:
- wr_en = 1;
- wr_addr = the current address;
- wr_instr = the latched instruction byte;
- wr_arg = byte_in.
The write latency is one cycle after the ARG transfer.
REQ-021 After an ARG transfer the address SHALL increment. If it now equals N, the FSM goes to CHK (macro defined) or DONE (macro not defined); otherwise it goes to INSTR.
REQ-022 Addresses SHALL run 0..N-1 only, with N at most 2**WIDTH-1; the address counter SHALL never wrap.
REQ-023 In DONE, for exactly one cycle, done SHALL be 1 and cpu_hold SHALL be 0; the FSM then returns to IDLE.
REQ-024 A start received in any state other than IDLE SHALL be ignored.
REQ-025 Cycles with byte_valid = 0 SHALL stall the FSM with no change of state or outputs, and a stall of any length SHALL be legal.
REQ-026 wr_addr, wr_instr and wr_arg SHALL hold their last values whenever wr_en = 0.

Reset
REQ-027 rst SHALL take priority over all other inputs.
REQ-028 rst SHALL force the following on the next edge:
- state = IDLE;
- byte_ready, wr_en, done, err and cpu_hold = 0;
- wr_addr, wr_instr, wr_arg, N, the address counter and the checksum = 0.
REQ-029 An rst asserted mid-load SHALL abandon the load with no further writes; memory contents already written SHALL stay as they are.

Configuration
REQ-030 When PROG_LOADER_CHKSUM_EN is defined, the checksum SHALL be the XOR of every instr and arg byte transferred, excluding the length byte.
REQ-031 With PROG_LOADER_CHKSUM_EN defined, CHK SHALL accept one byte and compare it with the checksum:
- match: go to DONE;
- mismatch: err = 1, cpu_hold stays 1, done is not pulsed, and the FSM returns to IDLE.
REQ-032 When PROG_LOADER_CHKSUM_EN is not defined:
- the CHK state and the checksum register SHALL be omitted;
- err SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration and the state encoding width.
REQ-034 The block SHALL be written as a single module with no sub-modules.
REQ-035 In the CPU top level, cpu_hold SHALL be ORed into the PC reset, and the wr_* signals SHALL drive the write port of the program ROM.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- No checksum, continuous valid, stream 02,11,22,33,44 -> writes (00,11,22) then (01,33,44); one done pulse; cpu_hold 1 from the cycle after start until the done cycle.
- Checksum enabled, stream 01,A5,0F,AA -> write (00,A5,0F), done = 1, err = 0.
- Checksum enabled, stream 01,A5,0F,00 -> err = 1, no done pulse, cpu_hold stays 1, and the next start clears err.
- Length 00 (with the checksum byte 00 when the macro is enabled) -> no writes; done pulses.
- byte_valid held low for 5 cycles between the instr byte and the arg byte -> the write is delayed and its data is unchanged.
- rst asserted after the first write of a 3-word load -> everything returns to reset values, no further wr_en, and start is accepted again afterwards.
